// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned ADDR_WIDTH      = 32;
   localparam int unsigned DMEM_WAIT_WIDTH = 4;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [XLEN-1:0]       data_t;
   typedef logic [3:0]            strb_t;

   typedef enum logic [2:0] {
      LOAD_LB  = 3'b000,
      LOAD_LH  = 3'b001,
      LOAD_LW  = 3'b010,
      LOAD_LBU = 3'b100,
      LOAD_LHU = 3'b101
   } LOAD_FUNCT3;

   typedef enum logic [2:0] {
      STORE_SB = 3'b000,
      STORE_SH = 3'b001,
      STORE_SW = 3'b010
   } STORE_FUNCT3;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_WAIT,
      DMEM_RESP
   } dmem_state_t;

endpackage

// File: rtl/dmem_responder_lane.sv
// Combinational byte-lane steering: store strobes/data, load extension, legality.
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic       i_we,
   input  logic [2:0] i_funct3,
   input  logic [1:0] i_off,
   input  data_t      i_wdata,
   input  data_t      i_rword,
   output strb_t      o_strb_c,
   output data_t      o_wdata_c,
   output data_t      o_rdata_c,
   output logic       o_misalign_c,
   output logic       o_illegal_c
);

   data_t      w_rshift_b;
   data_t      w_rshift_h;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_rshift_b = i_rword >> {i_off, 3'b000};
   assign w_rshift_h = i_rword >> {i_off[1], 4'b0000};
   assign w_byte     = w_rshift_b[7:0];
   assign w_half     = w_rshift_h[15:0];

   // Decode access size, steer lanes and flag bad encodings/alignment.
   always_comb begin
      o_strb_c     = '0;
      o_wdata_c    = '0;
      o_rdata_c    = '0;
      o_misalign_c = 1'b0;
      o_illegal_c  = 1'b0;
      if (i_we) begin
         case (i_funct3)
            STORE_SB: begin
               o_strb_c  = strb_t'(4'b0001 << i_off);
               o_wdata_c = {4{i_wdata[7:0]}};
            end
            STORE_SH: begin
               o_misalign_c = i_off[0];
               o_strb_c     = i_off[1] ? 4'b1100 : 4'b0011;
               o_wdata_c    = {2{i_wdata[15:0]}};
            end
            STORE_SW: begin
               o_misalign_c = |i_off;
               o_strb_c     = 4'b1111;
               o_wdata_c    = i_wdata;
            end
            default: o_illegal_c = 1'b1;
         endcase
      end else begin
         case (i_funct3)
            LOAD_LB:  o_rdata_c = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: o_rdata_c = {24'd0, w_byte};
            LOAD_LH: begin
               o_misalign_c = i_off[0];
               o_rdata_c    = {{16{w_half[15]}}, w_half};
            end
            LOAD_LHU: begin
               o_misalign_c = i_off[0];
               o_rdata_c    = {16'd0, w_half};
            end
            LOAD_LW: begin
               o_misalign_c = |i_off;
               o_rdata_c    = i_rword;
            end
            default: o_illegal_c = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accept, wait states, single-edge access, held response.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned MEM_DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES     = 2,
   parameter addr_t       BASE_ADDR       = 32'h0000_0000
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [2:0] req_funct3,
   input  addr_t      req_addr,
   input  data_t      req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output data_t      rsp_rdata,
   output logic       rsp_err
);

   localparam int unsigned IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
   localparam logic [DMEM_WAIT_WIDTH-1:0] WAIT_INIT =
      (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_WIDTH'(WAIT_CYCLES - 1);

   dmem_state_t                r_state, w_state_nxt;
   logic [DMEM_WAIT_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic                       w_enter_resp;

   logic       r_we;
   logic [2:0] r_funct3;
   addr_t      r_addr;
   data_t      r_wdata;

   logic       r_req_ready;
   logic       r_rsp_valid;
   data_t      r_rsp_rdata;
   logic       r_rsp_err;

   data_t      r_mem [MEM_DEPTH_WORDS];

   // With zero wait states the access happens on the accept edge, before the latches load.
   logic       w_acc_we;
   logic [2:0] w_acc_funct3;
   addr_t      w_acc_addr;
   data_t      w_acc_wdata;
   addr_t      w_off;
   logic [IDX_W-1:0] w_idx;
   logic       w_oor;
   data_t      w_rword;
   strb_t      w_strb;
   data_t      w_wdata_sh;
   data_t      w_rdata_ext;
   logic       w_misalign;
   logic       w_illegal;
   logic       w_err;
   logic       w_commit;

   assign w_acc_we     = (r_state == DMEM_IDLE) ? req_we     : r_we;
   assign w_acc_funct3 = (r_state == DMEM_IDLE) ? req_funct3 : r_funct3;
   assign w_acc_addr   = (r_state == DMEM_IDLE) ? req_addr   : r_addr;
   assign w_acc_wdata  = (r_state == DMEM_IDLE) ? req_wdata  : r_wdata;

   assign w_off   = w_acc_addr - BASE_ADDR;
   assign w_idx   = w_off[IDX_W+1:2];
   assign w_oor   = ({2'b00, w_off[31:2]} >= 32'(MEM_DEPTH_WORDS));
   assign w_rword = r_mem[w_idx];
   assign w_err   = w_oor | w_misalign | w_illegal;
   assign w_commit = rst_n & w_enter_resp & w_acc_we & ~w_err;

   dmem_lane_align u_lane (
      .i_we         (w_acc_we),
      .i_funct3     (w_acc_funct3),
      .i_off        (w_off[1:0]),
      .i_wdata      (w_acc_wdata),
      .i_rword      (w_rword),
      .o_strb_c     (w_strb),
      .o_wdata_c    (w_wdata_sh),
      .o_rdata_c    (w_rdata_ext),
      .o_misalign_c (w_misalign),
      .o_illegal_c  (w_illegal)
   );

   // Next-state and wait-counter logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_enter_resp = 1'b0;
      case (r_state)
         DMEM_IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt  = DMEM_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_nxt = DMEM_WAIT;
                  w_cnt_nxt   = WAIT_INIT;
               end
            end
         end
         DMEM_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt  = DMEM_RESP;
               w_enter_resp = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - DMEM_WAIT_WIDTH'(1);
            end
         end
         DMEM_RESP: begin
            if (rsp_ready) w_state_nxt = DMEM_IDLE;
         end
         default: w_state_nxt = DMEM_IDLE;
      endcase
   end

   // State, request latches and registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= DMEM_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_funct3    <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= (w_state_nxt == DMEM_IDLE);
         if (r_state == DMEM_IDLE && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
         end
         if (w_enter_resp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (w_err || w_acc_we) ? '0 : w_rdata_ext;
            r_rsp_err   <= w_err;
         end else if (r_state == DMEM_RESP && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
         end
      end
   end

   // Byte-lane store commit on the RESP entry edge; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
         end
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a byte-addressed reference model.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
   logic [2:0]  z_req_funct3 = '0;
   logic [31:0] z_req_addr = '0, z_req_wdata = '0;
   logic        z_req_ready, z_rsp_valid, z_rsp_err;
   logic [31:0] z_rsp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] model_mem [0:4095];

   always #5 clk = ~clk;

   dmem_responder #(.MEM_DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.MEM_DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
      .req_we(z_req_we), .req_funct3(z_req_funct3), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
      .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
   );

   // Reference: memory as bytes, access size 1<<funct3[1:0], little-endian.
   function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd, output bit er);
      int unsigned sz = 1 << f3[1:0];
      bit bad = 0;
      logic [31:0] v = 0;
      logic [31:0] sgn;
      if (we && f3 >= 3) bad = 1;
      if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) bad = 1;
      if (addr / 4 >= 1024) bad = 1;
      if (!bad && (addr % sz) != 0) bad = 1;
      rd = 0;
      er = bad;
      if (bad) return;
      if (we) begin
         for (int i = 0; i < int'(sz); i++) model_mem[addr + i] = wd[8*i +: 8];
      end else begin
         for (int i = 0; i < int'(sz); i++) v = v + (32'(model_mem[addr + i]) << (8*i));
         if (!f3[2] && sz < 4) begin
            sgn = 32'd1 << (8*sz - 1);
            v = (v ^ sgn) - sgn;
         end
         rd = v;
      end
   endfunction

   // Drive one request on the WAIT_CYCLES=2 instance, hold the response 'hold' cycles, then retire it.
   task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output bit er, output int lat);
      int g = 0;
      @(negedge clk);
      req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      while (!req_ready && g < 50) begin @(negedge clk); g++; end
      n_checks++;
      if (g >= 50) begin n_fail++; $display("FAIL accept_timeout: req_ready stuck at %0d, wanted 1", req_ready); end
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 0;
      while (!rsp_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
      n_checks++;
      if (!rsp_valid) begin n_fail++; $display("FAIL rsp_timeout: rsp_valid=%0d after %0d cycles, wanted 1", rsp_valid, lat); end
      rd = rsp_rdata;
      er = rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_hold: valid=%0d rdata=%h err=%0d ready=%0d, wanted 1 %h %0d 0",
                     rsp_valid, rsp_rdata, rsp_err, req_ready, rd, er);
         end
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rsp_retire: valid=%0d rdata=%h err=%0d ready=%0d, wanted 0 0 0 1",
                  rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: valid=%0d rdata=%h err=%0d ready=%0d, wanted 0 0 0 1",
                  rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      n_checks++;
      if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state_w0: valid=%0d ready=%0d, wanted 0 1", z_rsp_valid, z_req_ready);
      end
   endtask

   task automatic test_init();
      logic [31:0] rd, erd, wd;
      bit er, eer;
      int lat;
      for (int w = 0; w < 64; w++) begin
         wd = $urandom;
         model(1, 3'b010, 32'(w*4), wd, erd, eer);
         txn(1, 3'b010, 32'(w*4), wd, 0, rd, er, lat);
         n_checks++;
         if (er !== eer) begin n_fail++; $display("FAIL init_sw: err=%0d wanted %0d", er, eer); end
      end
   endtask

   // One directed access: compare data, error and latency against the model.
   task automatic directed(input string name, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] want);
      logic [31:0] rd, erd;
      bit er, eer;
      int lat;
      model(we, f3, addr, wd, erd, eer);
      txn(we, f3, addr, wd, 1, rd, er, lat);
      n_checks++;
      if (rd !== want || rd !== erd || er !== eer || lat != 3) begin
         n_fail++;
         $display("FAIL %s: rdata=%h err=%0d lat=%0d, wanted %h %0d 3", name, rd, er, lat, want, eer);
      end
   endtask

   task automatic test_lanes();
      directed("sw_10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0);
      directed("lw_10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF);
      directed("sb_13", 1, 3'b000, 32'h13, 32'h00000080, 32'h0);
      directed("lw_10_sb", 0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF);
      directed("lb_13", 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80);
      directed("lbu_13", 0, 3'b100, 32'h13, 32'h0, 32'h00000080);
      directed("sh_12", 1, 3'b001, 32'h12, 32'h00001234, 32'h0);
      directed("lw_10_sh", 0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF);
      directed("lh_12", 0, 3'b001, 32'h12, 32'h0, 32'h00001234);
   endtask

   task automatic test_errors();
      logic [31:0] rd, erd;
      bit er, eer;
      int lat;
      txn(0, 3'b010, 32'h11, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_lw_11: err=%0d rdata=%h, wanted 1 0", er, rd); end
      txn(1, 3'b001, 32'h15, 32'hFFFF, 0, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_sh_15: err=%0d rdata=%h, wanted 1 0", er, rd); end
      txn(0, 3'b010, 32'h1000, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_lw_1000: err=%0d rdata=%h, wanted 1 0", er, rd); end
      txn(1, 3'b011, 32'h10, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (er !== 1'b1) begin n_fail++; $display("FAIL err_store_f3: err=%0d, wanted 1", er); end
      model(0, 3'b010, 32'h10, 32'h0, erd, eer);
      txn(0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h1234BEEF || rd !== erd || er !== 1'b0) begin
         n_fail++; $display("FAIL err_mem_intact: rdata=%h err=%0d, wanted 1234beef 0", rd, er);
      end
   endtask

   task automatic test_hold();
      logic [31:0] rd, erd1, erd2;
      bit er, eer;
      int lat = 1, g = 0;
      model(0, 3'b010, 32'h10, 32'h0, erd1, eer);
      model(0, 3'b010, 32'h04, 32'h0, erd2, eer);
      @(negedge clk);
      req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk);
      @(negedge clk);
      req_addr = 32'h04;
      while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
      rd = rsp_rdata;
      n_checks++;
      if (rd !== erd1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL hold_first: rdata=%h err=%0d, wanted %h 0", rd, rsp_err, erd1); end
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== erd1 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable: valid=%0d rdata=%h err=%0d ready=%0d, wanted 1 %h 0 0",
                     rsp_valid, rsp_rdata, rsp_err, req_ready, erd1);
         end
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_handshake: valid=%0d ready=%0d, wanted 0 1", rsp_valid, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      while (!rsp_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
      n_checks++;
      if (rsp_rdata !== erd2 || lat != 3) begin
         n_fail++; $display("FAIL hold_second: rdata=%h lat=%0d, wanted %h 3", rsp_rdata, lat, erd2);
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd;
      bit er, eer;
      int lat, g = 0;
      // Reset during WAIT: store must not land.
      @(negedge clk);
      req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      rst_n = 0;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_wait: valid=%0d ready=%0d, wanted 0 1", rsp_valid, req_ready);
      end
      @(negedge clk);
      rst_n = 1;
      model(0, 3'b010, 32'h20, 32'h0, erd, eer);
      txn(0, 3'b010, 32'h20, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (rd !== erd || er !== 1'b0) begin n_fail++; $display("FAIL rst_wait_nowrite: rdata=%h, wanted %h", rd, erd); end
      // Reset during RESP: store already committed, response dropped at once.
      @(negedge clk);
      req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h24; req_wdata = 32'h5A5A1234;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
      rst_n = 0;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL rst_resp: valid=%0d err=%0d, wanted 0 0", rsp_valid, rsp_err);
      end
      model(1, 3'b010, 32'h24, 32'h5A5A1234, erd, eer);
      @(negedge clk);
      rst_n = 1;
      model(0, 3'b010, 32'h24, 32'h0, erd, eer);
      txn(0, 3'b010, 32'h24, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (rd !== erd || rd !== 32'h5A5A1234) begin n_fail++; $display("FAIL rst_resp_written: rdata=%h, wanted 5a5a1234", rd); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] wd = $urandom;
      int lat;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         z_req_valid = 1; z_req_we = (k == 0); z_req_funct3 = 3'b010; z_req_addr = 32'h40; z_req_wdata = wd;
         @(posedge clk);
         lat = 1;
         @(negedge clk);
         z_req_valid = 0;
         while (!z_rsp_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
         n_checks++;
         if (lat != 1 || z_rsp_err !== 1'b0 || z_rsp_rdata !== ((k == 0) ? 32'h0 : wd)) begin
            n_fail++;
            $display("FAIL zero_wait_%0d: lat=%0d err=%0d rdata=%h, wanted 1 0 %h",
                     k, lat, z_rsp_err, z_rsp_rdata, (k == 0) ? 32'h0 : wd);
         end
         z_rsp_ready = 1;
         @(negedge clk);
         z_rsp_ready = 0;
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, addr, wd;
      logic [2:0]  f3;
      bit er, eer, we;
      int lat;
      for (int n = 0; n < 150; n++) begin
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         wd   = $urandom;
         addr = ($urandom_range(0, 7) == 0) ? (32'h1000 + 32'($urandom_range(0, 255))) : 32'($urandom_range(0, 255));
         model(we, f3, addr, wd, erd, eer);
         txn(we, f3, addr, wd, $urandom_range(0, 3), rd, er, lat);
         n_checks++;
         if (rd !== erd || er !== eer || lat != 3) begin
            n_fail++;
            $display("FAIL random_%0d we=%0d f3=%0d addr=%h: rdata=%h err=%0d lat=%0d, wanted %h %0d 3",
                     n, we, f3, addr, rd, er, lat, erd, eer);
         end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_lanes();
      test_errors();
      test_hold();
      test_reset_mid();
      test_zero_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the core's MEM-stage load/store port. It is the responder end of the request/response handshake that the pipeline initiates.
- Accepts one request at a time, inserts a programmable number of wait states, then performs the access on an internal word array. Stores are written with byte/halfword lanes; load data is returned fully extended per LOAD_FUNCT3.
- Flags misaligned, out-of-range and illegal-funct3 accesses.

Parameters:
- MEM_DEPTH_WORDS, 1024: number of 32-bit words in the array.
- WAIT_CYCLES, 2: wait states between accept and response (0..15).
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  LOAD_FUNCT3 / STORE_FUNCT3 encoding.
- req_addr  in  ADDR_WIDTH  byte address (addr_t).
- req_wdata  in  XLEN  store data, right-aligned (data_t).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  access fault.

Interface (decided): one clock; reset is asynchronous and active-low (rst_n).

Behaviour:
- States: IDLE, WAIT, RESP. Reset forces IDLE.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, request latches=0. req_ready=1 in IDLE after reset. Array contents are not reset.
- IDLE: req_ready=1. When req_valid=1 the request fields are latched.
  - Next state is WAIT with counter=WAIT_CYCLES-1.
  - If WAIT_CYCLES=0, next state is RESP.
- WAIT: req_ready=0. The counter decrements each cycle; at 0 the next state is RESP.
- Entering RESP (single edge):
  - Error check and access are performed.
  - rsp_valid=1; rsp_rdata and rsp_err are registered.
  - The store write is committed on this same edge, exactly once.
- RESP: req_ready=0. rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1. On that handshake:
  - next state is IDLE;
  - rsp_valid=0 next cycle;
  - rsp_rdata and rsp_err are cleared to 0.
- Latency: request accept edge to rsp_valid high is WAIT_CYCLES+1 cycles. Minimum request spacing is WAIT_CYCLES+2 cycles (no accept in RESP).
- Addressing:
  - off = addr - BASE_ADDR (32-bit wrap).
  - Word index = off[31:2]; byte lane = off[1:0].
- Errors (any one sets rsp_err=1; no write occurs and rdata=0):
  - index >= MEM_DEPTH_WORDS;
  - halfword access with off[0]=1;
  - word access with off[1:0]!=0;
  - load funct3 in {011, 110, 111};
  - store funct3 >= 011.
- Store lanes:
  - SB writes byte lane off[1:0] with wdata[7:0].
  - SH writes lanes {off[1],0} and {off[1],1} with wdata[15:0].
  - SW writes all 4 lanes.
  - All other bytes are unchanged.
- Load extension:
  - LB/LH sign-extend the selected byte/half.
  - LBU/LHU zero-extend.
  - LW returns the word.
- Requests arriving while req_ready=0 are ignored; the initiator must hold them.
- Reset mid-operation:
  - In WAIT, the pending store is abandoned with no write.
  - In RESP, the write has already been committed; the response is dropped.

Decomposition:
- Add to package defs:
  - dmem_state_t enum {DMEM_IDLE, DMEM_WAIT, DMEM_RESP};
  - strb_t (logic [3:0]) byte-strobe typedef;
  - DMEM_WAIT_WIDTH = 4.
- Reuse the existing LOAD_FUNCT3, STORE_FUNCT3, addr_t and data_t.
- Sub-module dmem_lane_align: purely combinational.
  - Inputs: funct3, off[1:0], wdata, read word.
  - Outputs: strobe, shifted write data, extended load data, misalign/illegal flags.
  - The FSM, counter and array stay in the top.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 with WAIT_CYCLES=2 -> rsp_valid exactly 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
- SB 0x13 data 0x80, then LB 0x13 and LBU 0x13 -> word at 0x10 reads 0x80ADBEEF; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH 0x12 data 0x1234, then LH 0x12 -> word reads 0x1234BEEF; LH returns 0x00001234.
- Misaligned LW 0x11, misaligned SH 0x15, and LW 0x1000 (depth 1024) -> each gives err=1 and rdata=0; a following LW 0x10 shows the memory unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP while req_valid=1 with new fields -> rsp_* stable, req_ready=0, new request accepted only in the cycle after the handshake.
- Assert rst_n=0 during WAIT of SW 0x20 data 0xA5A5A5A5, release, then LW 0x20 -> rsp_valid=0 immediately on reset and the old contents of 0x20 are returned. Also check WAIT_CYCLES=0 gives 1-cycle latency.
